// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB front-end of the I2C core: FSM state type,
// register offsets, interrupt and STATUS bit positions.
package apb_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int TXDATA_OFS   = 'h00;
    localparam int RXDATA_OFS   = 'h04;
    localparam int CFG_BASE_OFS = 'h08;

    localparam int INT_W    = 3;
    localparam int INT_TXE  = 0;
    localparam int INT_RXNE = 1;
    localparam int INT_ERR  = 2;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_ERROR    = 3;

    // STATUS sits directly after the last config register.
    function automatic int status_ofs(input int num_cfg);
        return CFG_BASE_OFS + 4 * num_cfg;
    endfunction

endpackage

// File: rtl/apb_i2c_regbank_if.sv
// APB completer-side bus bundle. Optional byte strobes under APB4_PSTRB_EN.
interface apb_i2c_regbank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
`ifdef APB4_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;
`endif
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB4_PSTRB_EN
        output PSTRB,
`endif
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB4_PSTRB_EN
        input  PSTRB,
`endif
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_int_ctrl.sv
// Interrupt block: edge detection on the FIFO/error levels, sticky status
// with write-1-to-clear, byte-maskable enable mask and the derived outputs.
module apb_i2c_int_ctrl
    import apb_i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_empty,
    input  logic             rx_empty,
    input  logic             error,
    input  logic [INT_W-1:0] stat_clr,
    input  logic             mask_we,
    input  logic [INT_W-1:0] mask_wdata,
    input  logic [INT_W-1:0] mask_bmask,
    output logic [INT_W-1:0] stat,
    output logic [INT_W-1:0] mask,
    output logic             int_tx,
    output logic             int_rx,
    output logic             irq
);
    logic [INT_W-1:0] src;
    logic [INT_W-1:0] src_prev_q;
    logic [INT_W-1:0] rise;
    logic [INT_W-1:0] stat_q;
    logic [INT_W-1:0] mask_q;

    // RX "data arrived" is the falling edge of RX_EMPTY, so invert it here.
    always_comb begin
        src           = '0;
        src[INT_TXE]  = tx_empty;
        src[INT_RXNE] = ~rx_empty;
        src[INT_ERR]  = error;
        rise          = src & ~src_prev_q;
    end

    // Previous-level capture; during reset it tracks the inputs so that
    // levels already present at reset release do not fake an edge.
    always_ff @(posedge clk) begin
        src_prev_q <= src;
    end

    // Sticky status: a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) stat_q <= '0;
        else     stat_q <= (stat_q & ~stat_clr) | rise;
    end

    // Interrupt enable mask, written under the byte-lane mask.
    always_ff @(posedge clk) begin
        if (rst)          mask_q <= '0;
        else if (mask_we) mask_q <= (mask_q & ~mask_bmask) | (mask_wdata & mask_bmask);
    end

    assign stat   = stat_q;
    assign mask   = mask_q;
    assign int_tx = stat_q[INT_TXE] & mask_q[INT_TXE];
    assign int_rx = stat_q[INT_RXNE] & mask_q[INT_RXNE];
    assign irq    = |(stat_q & mask_q);

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB completer front-end for the I2C core: TX/RX FIFO ports, NUM_CFG config
// registers, STATUS, and a sticky maskable interrupt block.
// Optional feature macro: APB4_PSTRB_EN (byte write strobes).
module apb_i2c_regbank
    import apb_i2c_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int CFG_W       = 14,
    parameter int NUM_CFG     = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    apb_i2c_regbank_if.slave         apb,
    input  logic [DATA_W-1:0]        READ_DATA_ON_RX,
    input  logic                     TX_FULL,
    input  logic                     TX_EMPTY,
    input  logic                     RX_EMPTY,
    input  logic                     ERROR,
    output logic [DATA_W-1:0]        WRITE_DATA_ON_TX,
    output logic                     WR_ENA,
    output logic                     RD_ENA,
    output logic [NUM_CFG*CFG_W-1:0] I2C_CFG,
    output logic                     INT_TX,
    output logic                     INT_RX,
    output logic                     IRQ
);
    localparam int STATUS_OFS  = status_ofs(NUM_CFG);
    localparam int INTSTAT_OFS = STATUS_OFS + 4;
    localparam int INTMASK_OFS = STATUS_OFS + 8;

`ifdef APB4_PSTRB_EN
    function automatic logic [DATA_W-1:0] expand_strb(input logic [DATA_W/8-1:0] s);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < DATA_W/8; b++) r[b*8 +: 8] = {8{s[b]}};
        return r;
    endfunction
`endif

    apb_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               xfer_done;
    logic               fire;

    logic               hit_tx, hit_rx, hit_stat, hit_istat, hit_imask;
    logic [NUM_CFG-1:0] cfg_sel;
    logic               mapped;
    logic               slverr;
    logic               wr_ok, rd_ok;
    logic [DATA_W-1:0]  byte_mask;
    logic               strb_full;
    logic [DATA_W-1:0]  rdata_mux;

    logic [CFG_W-1:0]   cfg_q [NUM_CFG];
    logic [INT_W-1:0]   int_stat, int_mask;

    // Transfer state register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. SETUP is held during the first enable cycle, so with no
    // wait states the transfer completes there; otherwise ACCESS counts down
    // the remaining WAIT_STATES cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        xfer_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.PSELx && !apb.PENABLE) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (!apb.PSELx) begin
                    state_d = ST_IDLE;
                end else if (apb.PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        xfer_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_ACCESS: begin
                if (!apb.PSELx) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    xfer_done = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset in the completion cycle must not leak a PREADY or strobe.
    assign fire = xfer_done & ~PRESET;

    // Address decode, byte strobes and error classification.
    always_comb begin
        hit_tx    = apb.PADDR == ADDR_W'(TXDATA_OFS);
        hit_rx    = apb.PADDR == ADDR_W'(RXDATA_OFS);
        hit_stat  = apb.PADDR == ADDR_W'(STATUS_OFS);
        hit_istat = apb.PADDR == ADDR_W'(INTSTAT_OFS);
        hit_imask = apb.PADDR == ADDR_W'(INTMASK_OFS);
        cfg_sel   = '0;
        for (int i = 0; i < NUM_CFG; i++)
            cfg_sel[i] = apb.PADDR == ADDR_W'(CFG_BASE_OFS + 4 * i);
        mapped = hit_tx | hit_rx | hit_stat | hit_istat | hit_imask | (|cfg_sel);
`ifdef APB4_PSTRB_EN
        byte_mask = expand_strb(apb.PSTRB);
        strb_full = &apb.PSTRB;
`else
        byte_mask = '1;
        strb_full = 1'b1;
`endif
        slverr = !mapped
               | ( apb.PWRITE & (hit_rx | hit_stat))
               | (!apb.PWRITE & hit_tx)
               | ( apb.PWRITE & hit_tx & (TX_FULL | !strb_full))
               | (!apb.PWRITE & hit_rx & RX_EMPTY);
        wr_ok = fire &  apb.PWRITE & !slverr;
        rd_ok = fire & !apb.PWRITE & !slverr;
    end

    // Read data mux, zero-extended register contents.
    always_comb begin
        rdata_mux = '0;
        if (hit_rx)    rdata_mux = READ_DATA_ON_RX;
        if (hit_stat)  rdata_mux = DATA_W'({ERROR, RX_EMPTY, TX_EMPTY, TX_FULL});
        if (hit_istat) rdata_mux = DATA_W'(int_stat);
        if (hit_imask) rdata_mux = DATA_W'(int_mask);
        for (int i = 0; i < NUM_CFG; i++)
            if (cfg_sel[i]) rdata_mux = DATA_W'(cfg_q[i]);
    end

    // Config registers, byte-merged under the write strobes.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++)
                if (wr_ok && cfg_sel[i])
                    cfg_q[i] <= (cfg_q[i] & ~byte_mask[CFG_W-1:0])
                              | (apb.PWDATA[CFG_W-1:0] & byte_mask[CFG_W-1:0]);
        end
    end

    // Flatten config registers onto the core-facing bus.
    always_comb begin
        I2C_CFG = '0;
        for (int i = 0; i < NUM_CFG; i++) I2C_CFG[i*CFG_W +: CFG_W] = cfg_q[i];
    end

    apb_i2c_int_ctrl u_int_ctrl (
        .clk        (PCLK),
        .rst        (PRESET),
        .tx_empty   (TX_EMPTY),
        .rx_empty   (RX_EMPTY),
        .error      (ERROR),
        .stat_clr   ((wr_ok && hit_istat) ? (apb.PWDATA[INT_W-1:0] & byte_mask[INT_W-1:0])
                                          : {INT_W{1'b0}}),
        .mask_we    (wr_ok && hit_imask),
        .mask_wdata (apb.PWDATA[INT_W-1:0]),
        .mask_bmask (byte_mask[INT_W-1:0]),
        .stat       (int_stat),
        .mask       (int_mask),
        .int_tx     (INT_TX),
        .int_rx     (INT_RX),
        .irq        (IRQ)
    );

    assign apb.PREADY       = fire;
    assign apb.PSLVERR      = fire & slverr;
    assign apb.PRDATA       = rd_ok ? rdata_mux : '0;
    assign WRITE_DATA_ON_TX = apb.PWDATA;
    assign WR_ENA           = wr_ok & hit_tx;
    assign RD_ENA           = rd_ok & hit_rx;

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Directed bench for apb_i2c_regbank: three instances with 0, 2 and 3 wait
// states share the stimulus; sel routes the APB select to one of them.
module tb_apb_i2c_regbank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] rx_head = '0;
    logic        tx_full = 1'b0, tx_empty = 1'b1, rx_empty = 1'b1, error_in = 1'b0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    apb_i2c_regbank_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    apb_i2c_regbank_if #(.ADDR_W(32), .DATA_W(32)) if2 ();
    apb_i2c_regbank_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    assign if0.PSELx = psel && (sel == 2'd0);
    assign if2.PSELx = psel && (sel == 2'd2);
    assign if3.PSELx = psel && (sel == 2'd3);
    assign if0.PENABLE = penable; assign if2.PENABLE = penable; assign if3.PENABLE = penable;
    assign if0.PWRITE  = pwrite;  assign if2.PWRITE  = pwrite;  assign if3.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;   assign if2.PADDR   = paddr;   assign if3.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;  assign if2.PWDATA  = pwdata;  assign if3.PWDATA  = pwdata;
`ifdef APB4_PSTRB_EN
    assign if0.PSTRB = '1; assign if2.PSTRB = '1; assign if3.PSTRB = '1;
`endif

    logic [31:0] txd0, txd2, txd3;
    logic        wr0, wr2, wr3, rd0, rd2, rd3;
    logic [27:0] cfg0, cfg2, cfg3;
    logic        itx0, itx2, itx3, irx0, irx2, irx3, irq0, irq2, irq3;

    apb_i2c_regbank #(.WAIT_STATES(0)) u0 (
        .PCLK(clk), .PRESET(rst), .apb(if0), .READ_DATA_ON_RX(rx_head),
        .TX_FULL(tx_full), .TX_EMPTY(tx_empty), .RX_EMPTY(rx_empty), .ERROR(error_in),
        .WRITE_DATA_ON_TX(txd0), .WR_ENA(wr0), .RD_ENA(rd0), .I2C_CFG(cfg0),
        .INT_TX(itx0), .INT_RX(irx0), .IRQ(irq0));
    apb_i2c_regbank #(.WAIT_STATES(2)) u2 (
        .PCLK(clk), .PRESET(rst), .apb(if2), .READ_DATA_ON_RX(rx_head),
        .TX_FULL(tx_full), .TX_EMPTY(tx_empty), .RX_EMPTY(rx_empty), .ERROR(error_in),
        .WRITE_DATA_ON_TX(txd2), .WR_ENA(wr2), .RD_ENA(rd2), .I2C_CFG(cfg2),
        .INT_TX(itx2), .INT_RX(irx2), .IRQ(irq2));
    apb_i2c_regbank #(.WAIT_STATES(3)) u3 (
        .PCLK(clk), .PRESET(rst | rst3), .apb(if3), .READ_DATA_ON_RX(rx_head),
        .TX_FULL(tx_full), .TX_EMPTY(tx_empty), .RX_EMPTY(rx_empty), .ERROR(error_in),
        .WRITE_DATA_ON_TX(txd3), .WR_ENA(wr3), .RD_ENA(rd3), .I2C_CFG(cfg3),
        .INT_TX(itx3), .INT_RX(irx3), .IRQ(irq3));

    logic        m_ready, m_err, m_wr, m_rd, m_itx, m_irx, m_irq;
    logic [31:0] m_rdata, m_txd;
    logic [27:0] m_cfg;

    always_comb begin
        m_ready = if0.PREADY; m_err = if0.PSLVERR; m_rdata = if0.PRDATA; m_txd = txd0;
        m_wr = wr0; m_rd = rd0; m_cfg = cfg0; m_itx = itx0; m_irx = irx0; m_irq = irq0;
        case (sel)
            2'd2: begin
                m_ready = if2.PREADY; m_err = if2.PSLVERR; m_rdata = if2.PRDATA; m_txd = txd2;
                m_wr = wr2; m_rd = rd2; m_cfg = cfg2; m_itx = itx2; m_irx = irx2; m_irq = irq2;
            end
            2'd3: begin
                m_ready = if3.PREADY; m_err = if3.PSLVERR; m_rdata = if3.PRDATA; m_txd = txd3;
                m_wr = wr3; m_rd = rd3; m_cfg = cfg3; m_itx = itx3; m_irx = irx3; m_irq = irq3;
            end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        wr_cnt <= wr_cnt + (m_wr ? 1 : 0);
        rd_cnt <= rd_cnt + (m_rd ? 1 : 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; n = enable cycles up to and including PREADY.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic err_rise, output logic [31:0] rd, output logic serr,
                       output int n, output logic [31:0] txd);
        logic done;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (err_rise) error_in = 1'b1;
        n = 0; rd = '0; serr = 1'b0; txd = '0; done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (m_ready) begin
                rd = m_rdata; serr = m_err; txd = m_txd; done = 1'b1;
            end
        end
        if (!done) check("pready_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd, txd;
    logic        serr;
    int          n, snap;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pready", 64'(m_ready), 64'd0);
        check("rst_pslverr", 64'(m_err), 64'd0);
        check("rst_prdata", 64'(m_rdata), 64'd0);
        check("rst_wr_rd", 64'({m_wr, m_rd}), 64'd0);
        check("rst_cfg", 64'(m_cfg), 64'd0);
        check("rst_irq", 64'({m_irq, m_itx, m_irx}), 64'd0);

        // STATUS read, zero wait states
        apb(1'b0, 32'h10, 32'h0, 1'b0, rd, serr, n, txd);
        check("status_data", 64'(rd), 64'h6);
        check("status_err", 64'(serr), 64'd0);
        check("status_lat", 64'(n), 64'd1);
        @(negedge clk);
        check("pready_one_cycle", 64'(m_ready), 64'd0);
        apb(1'b0, 32'h14, 32'h0, 1'b0, rd, serr, n, txd);
        check("intstat_rst", 64'(rd), 64'h0);

        // TXDATA writes
        tx_full = 1'b1; snap = wr_cnt;
        apb(1'b1, 32'h00, 32'hA5, 1'b0, rd, serr, n, txd);
        check("tx_full_err", 64'(serr), 64'd1);
        check("tx_full_nostrobe", 64'(wr_cnt - snap), 64'd0);
        tx_full = 1'b0; snap = wr_cnt;
        apb(1'b1, 32'h00, 32'hA5, 1'b0, rd, serr, n, txd);
        check("tx_ok_err", 64'(serr), 64'd0);
        check("tx_data", 64'(txd), 64'hA5);
        check("tx_strobe", 64'(wr_cnt - snap), 64'd1);

        // Illegal directions and empty RX
        apb(1'b0, 32'h00, 32'h0, 1'b0, rd, serr, n, txd);
        check("rd_txdata_err", 64'(serr), 64'd1);
        apb(1'b1, 32'h10, 32'h1, 1'b0, rd, serr, n, txd);
        check("wr_status_err", 64'(serr), 64'd1);
        snap = rd_cnt;
        apb(1'b0, 32'h04, 32'h0, 1'b0, rd, serr, n, txd);
        check("rx_empty_err", 64'(serr), 64'd1);
        check("rx_empty_nostrobe", 64'(rd_cnt - snap), 64'd0);

        // RXDATA read and unmapped addresses
        rx_empty = 1'b0; rx_head = 32'hDEAD; snap = rd_cnt;
        apb(1'b0, 32'h04, 32'h0, 1'b0, rd, serr, n, txd);
        check("rx_data", 64'(rd), 64'hDEAD);
        check("rx_err", 64'(serr), 64'd0);
        check("rx_strobe", 64'(rd_cnt - snap), 64'd1);
        apb(1'b0, 32'h40, 32'h0, 1'b0, rd, serr, n, txd);
        check("unmapped_err", 64'(serr), 64'd1);
        check("unmapped_data", 64'(rd), 64'h0);
        apb(1'b0, 32'h0A, 32'h0, 1'b0, rd, serr, n, txd);
        check("unaligned_err", 64'(serr), 64'd1);

        // CFG[1] truncation to CFG_W bits
        apb(1'b1, 32'h0C, 32'hFFFF_FFFF, 1'b0, rd, serr, n, txd);
        check("cfg1_flat", 64'(m_cfg), 64'h3FFF << 14);
        apb(1'b0, 32'h0C, 32'h0, 1'b0, rd, serr, n, txd);
        check("cfg1_read", 64'(rd), 64'h3FFF);

        // Interrupts
        rx_empty = 1'b1;
        apb(1'b1, 32'h14, 32'h7, 1'b0, rd, serr, n, txd);
        apb(1'b0, 32'h14, 32'h0, 1'b0, rd, serr, n, txd);
        check("intstat_cleared", 64'(rd), 64'h0);
        apb(1'b1, 32'h18, 32'h7, 1'b0, rd, serr, n, txd);
        apb(1'b0, 32'h18, 32'h0, 1'b0, rd, serr, n, txd);
        check("intmask_read", 64'(rd), 64'h7);
        check("irq_idle", 64'(m_irq), 64'd0);
        error_in = 1'b1;
        repeat (2) @(posedge clk);
        apb(1'b0, 32'h14, 32'h0, 1'b0, rd, serr, n, txd);
        check("err_stat", 64'(rd), 64'h4);
        check("err_irq", 64'({m_irq, m_itx, m_irx}), 64'b100);
        apb(1'b1, 32'h14, 32'h4, 1'b0, rd, serr, n, txd);
        apb(1'b0, 32'h14, 32'h0, 1'b0, rd, serr, n, txd);
        check("w1c_clear", 64'(rd), 64'h0);
        check("w1c_irq", 64'(m_irq), 64'd0);
        error_in = 1'b0;
        repeat (2) @(posedge clk);
        apb(1'b1, 32'h14, 32'h4, 1'b1, rd, serr, n, txd);
        apb(1'b0, 32'h14, 32'h0, 1'b0, rd, serr, n, txd);
        check("set_beats_clear", 64'(rd), 64'h4);
        check("set_beats_clear_irq", 64'(m_irq), 64'd1);
        #1 tx_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1 tx_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("int_tx", 64'(m_itx), 64'd1);
        apb(1'b0, 32'h14, 32'h0, 1'b0, rd, serr, n, txd);
        check("stat_txe_err", 64'(rd), 64'h5);
        apb(1'b1, 32'h18, 32'h4, 1'b0, rd, serr, n, txd);
        check("masked_int_tx", 64'({m_irq, m_itx}), 64'b10);

        // Two wait states
        sel = 2'd2;
        apb(1'b1, 32'h08, 32'h0000_1ABC, 1'b0, rd, serr, n, txd);
        check("ws2_lat", 64'(n), 64'd3);
        check("ws2_err", 64'(serr), 64'd0);
        check("ws2_cfg", 64'(m_cfg), 64'h1ABC);
        apb(1'b0, 32'h08, 32'h0, 1'b0, rd, serr, n, txd);
        check("ws2_read", 64'(rd), 64'h1ABC);
        snap = wr_cnt;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h77;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        check("abort_noready", 64'(m_ready), 64'd0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        repeat (4) @(posedge clk);
        check("abort_nostrobe", 64'(wr_cnt - snap), 64'd0);
        apb(1'b0, 32'h0C, 32'h0, 1'b0, rd, serr, n, txd);
        check("post_abort_lat", 64'(n), 64'd3);
        check("post_abort_data", 64'(rd), 64'h0);

        // Reset during ACCESS, three wait states
        sel = 2'd3;
        apb(1'b1, 32'h08, 32'h0123, 1'b0, rd, serr, n, txd);
        check("ws3_cfg", 64'(m_cfg), 64'h0123);
        snap = wr_cnt;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h2222;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ws3_wait", 64'(m_ready), 64'd0);
        @(posedge clk); #1 rst3 = 1'b1;
        @(negedge clk);
        check("rst_mid_noready", 64'(m_ready), 64'd0);
        @(posedge clk); #1 rst3 = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("rst_mid_cfg", 64'(m_cfg), 64'h0);
        check("rst_mid_ready", 64'(m_ready), 64'd0);
        apb(1'b1, 32'h0C, 32'h2222, 1'b0, rd, serr, n, txd);
        check("ws3_lat", 64'(n), 64'd4);
        check("ws3_cfg1", 64'(m_cfg), 64'h2222 << 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL global_timeout: simulation did not finish");
    end

endmodule
